// File: rtl/display_pkg.sv
// Shared constants for the seven-segment floor display: digit count, segment width
// and the hex glyph table (bit0 = segment a).
package display_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned SEG_W  = 7;

  localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

  localparam logic [SEG_W-1:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Purely combinational nibble-to-glyph decoder for a common-cathode seven-segment digit.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = GLYPHS[nibble];

endmodule

// File: rtl/floor_display.sv
// Four-digit time-multiplexed seven-segment driver with a blank slot per digit and
// frame-aligned double buffering of the displayed value and blank mask.
module floor_display
  import display_pkg::*;
#(
  parameter int unsigned DWELL = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       value,
  input  logic [DIGITS-1:0] blankMask,
  output logic [DIGITS-1:0] digitSel,
  output logic [SEG_W-1:0]  segments,
  output logic              frameDone,
  output logic              pending
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0]     slot_cnt;
  logic [1:0]        digit_idx;
  logic [15:0]       active_value;
  logic [15:0]       shadow_value;
  logic [DIGITS-1:0] active_mask;
  logic [DIGITS-1:0] shadow_mask;
  logic              pending_q;
  logic              slot_last;
  logic [3:0]        nibble;
  logic [SEG_W-1:0]  glyph;

  assign slot_last = (slot_cnt == CW'(DWELL - 1));
  assign frameDone = slot_last && (digit_idx == 2'd3);
  assign pending   = pending_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt     <= '0;
      digit_idx    <= '0;
      active_value <= '0;
      active_mask  <= '0;
      shadow_value <= '0;
      shadow_mask  <= '0;
      pending_q    <= 1'b0;
    end else begin
      slot_cnt <= slot_last ? '0 : slot_cnt + CW'(1);
      if (slot_last) begin
        digit_idx <= digit_idx + 2'd1;
      end
      // Transfer reads the shadow before this cycle's load can overwrite it.
      if (frameDone && pending_q) begin
        active_value <= shadow_value;
        active_mask  <= shadow_mask;
      end
      if (load) begin
        shadow_value <= value;
        shadow_mask  <= blankMask;
        pending_q    <= 1'b1;
      end else if (frameDone) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign nibble = active_value[{digit_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_comb begin
    digitSel = '0;
    segments = SEG_OFF;
    if (slot_cnt != '0) begin
      digitSel = DIGITS'(1) << digit_idx;
      if (!active_mask[digit_idx]) begin
        segments = glyph;
      end
    end
  end

endmodule

// File: tb/tb_floor_display.sv
// Directed self-checking bench for floor_display with DWELL=4 (16-cycle frames).
module tb_floor_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blankMask = '0;
  logic [3:0]  digitSel;
  logic [6:0]  segments;
  logic        frameDone;
  logic        pending;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  floor_display #(.DWELL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .blankMask (blankMask),
    .digitSel  (digitSel),
    .segments  (segments),
    .frameDone (frameDone),
    .pending   (pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks frame cycles from..to (ending on cycle `to`) given each digit's glyph.
  task automatic check_cycles(input int from, input int to, input logic [6:0] g0,
                              input logic [6:0] g1, input logic [6:0] g2,
                              input logic [6:0] g3, input logic [3:0] mask,
                              input logic pend, input string name);
    logic [6:0] g [4];
    logic [3:0] exp_sel;
    logic [6:0] exp_seg;
    int d;
    int ph;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    for (int s = from; s <= to; s++) begin
      d  = s / 4;
      ph = s % 4;
      exp_sel = (ph == 0) ? 4'd0 : (4'd1 << d);
      exp_seg = (ph == 0 || mask[d]) ? 7'h00 : g[d];
      check($sformatf("%s c%0d digitSel", name, s), {12'd0, digitSel}, {12'd0, exp_sel});
      check($sformatf("%s c%0d segments", name, s), {9'd0, segments}, {9'd0, exp_seg});
      check($sformatf("%s c%0d frameDone", name, s), {15'd0, frameDone},
            {15'd0, (s == 15)});
      check($sformatf("%s c%0d pending", name, s), {15'd0, pending}, {15'd0, pend});
      if (s < to) tick();
    end
  endtask

  initial begin
    // Reset held for three edges, then a blank cycle followed by digit 0 showing 0.
    rst = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check_cycles(0, 3, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b0, "reset");

    // Scan order: load 8421 at release, shown from the following frame.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    value = 16'h8421; blankMask = 4'h0; load = 1'b1;
    check_cycles(0, 0, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b0, "scan f0");
    tick();
    load = 1'b0;
    check_cycles(1, 15, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b1, "scan f0");
    tick();
    check_cycles(0, 15, 7'h06, 7'h5B, 7'h66, 7'h7F, 4'h0, 1'b0, "scan f1");
    tick();

    // Bring 1111 onto the display.
    value = 16'h1111; load = 1'b1;
    check_cycles(0, 0, 7'h06, 7'h5B, 7'h66, 7'h7F, 4'h0, 1'b0, "f2");
    tick();
    load = 1'b0;
    check_cycles(1, 15, 7'h06, 7'h5B, 7'h66, 7'h7F, 4'h0, 1'b1, "f2");
    tick();

    // Tear-free: load FFFF while digit 1 is driving.
    check_cycles(0, 5, 7'h06, 7'h06, 7'h06, 7'h06, 4'h0, 1'b0, "tear f3");
    value = 16'hFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    check_cycles(6, 15, 7'h06, 7'h06, 7'h06, 7'h06, 4'h0, 1'b1, "tear f3");
    tick();
    check_cycles(0, 15, 7'h71, 7'h71, 7'h71, 7'h71, 4'h0, 1'b0, "tear f4");
    tick();

    // Bring 0000 onto the display.
    value = 16'h0000; load = 1'b1;
    check_cycles(0, 0, 7'h71, 7'h71, 7'h71, 7'h71, 4'h0, 1'b0, "f5");
    tick();
    load = 1'b0;
    check_cycles(1, 15, 7'h71, 7'h71, 7'h71, 7'h71, 4'h0, 1'b1, "f5");
    tick();

    // Load coinciding with frameDone: 0001 lands first, 0002 one frame later.
    check_cycles(0, 2, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b0, "sim f6");
    value = 16'h0001; load = 1'b1;
    tick();
    load = 1'b0;
    check_cycles(3, 15, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b1, "sim f6");
    value = 16'h0002; load = 1'b1;
    tick();
    load = 1'b0;
    check_cycles(0, 15, 7'h06, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b1, "sim f7");
    tick();

    // Blank mask on digit 3 with value 1234.
    value = 16'h1234; blankMask = 4'b1000; load = 1'b1;
    check_cycles(0, 0, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b0, "mask f8");
    tick();
    load = 1'b0; blankMask = 4'h0;
    check_cycles(1, 15, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b1, "mask f8");
    tick();
    check_cycles(0, 15, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b1000, 1'b0, "mask f9");
    tick();

    // Reset during digit 2 with 5555 pending: active and shadow both discarded.
    value = 16'h5555; load = 1'b1;
    check_cycles(0, 0, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b1000, 1'b0, "rst f10");
    tick();
    load = 1'b0;
    check_cycles(1, 9, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b1000, 1'b1, "rst f10");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cycles(0, 15, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b0, "rst f0");
    tick();
    check_cycles(0, 15, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'h0, 1'b0, "rst f1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
